myth_run_monitor: RTL

Synthesizable run controller and result checker wrapped around the `core` processor. It generates the core's power-on reset pulse with parametrised delay and width, then watches the core's result bus. It declares pass when the bus holds an expected value for a programmable number of consecutive cycles, and fail on timeout. It replaces fixed-delay bench sequencing, so post-synthesis and FPGA runs self-check with no waveform inspection.

---
 rtl/myth_mon_pkg.sv | 24 ++
 rtl/myth_mon_cnt.sv | 48 ++++
 rtl/myth_run_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/myth_mon_pkg.sv
// Shared types, widths and helpers for the myth run monitor.
package myth_mon_pkg;

    localparam int unsigned RUN_CNT_W  = 16;
    localparam int unsigned STAB_CNT_W = 8;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_PRE  = 6'b000010,
        ST_RST  = 6'b000100,
        ST_RUN  = 6'b001000,
        ST_PASS = 6'b010000,
        ST_FAIL = 6'b100000
    } mon_state_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [RUN_CNT_W-1:0] sat_inc(
        input logic [RUN_CNT_W-1:0] val,
        input logic [RUN_CNT_W-1:0] max_val
    );
        return (val >= max_val) ? max_val : val + RUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/myth_mon_cnt.sv
// Loadable, enable-gated up/down counter that saturates at both ends.
module myth_mon_cnt
    import myth_mon_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         up_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Priority: clear, then load, then count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                cnt_d = W'(sat_inc(RUN_CNT_W'(cnt_q), RUN_CNT_W'(CNT_MAX)));
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/myth_run_monitor.sv
// Core run controller: sequences the core reset pulse, then declares pass on a
// stable expected result or fail on timeout.
module myth_run_monitor
    import myth_mon_pkg::*;
#(
    parameter int unsigned OUT_W       = 10,
    parameter int unsigned PRE_CYC     = 10,
    parameter int unsigned RST_CYC     = 100,
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OUT_W-1:0]     exp_val,
    input  logic [OUT_W-1:0]     core_out,
    output logic                 core_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [RUN_CNT_W-1:0] run_cycles,
    output logic [OUT_W-1:0]     last_out
);

    mon_state_t state_q, state_d;

    logic                  start_q, start_prev_q;
    logic [OUT_W-1:0]      exp_in_q, exp_q, last_q;
    logic                  core_reset_q, busy_q, done_q, pass_q, fail_q;
    logic                  core_reset_d, busy_d, done_d, pass_d, fail_d;

    logic                  start_rise, accept, run_step, mismatch;
    logic                  pass_hit, timeout_hit;
    logic                  iv_load;
    logic [RUN_CNT_W-1:0]  iv_val, iv_cnt, run_cnt;
    logic [STAB_CNT_W-1:0] stab_cnt;

    // start is registered first, so a held level yields a single rising event.
    assign start_rise  = start_q & ~start_prev_q;
    assign mismatch    = (core_out !== exp_q);
    assign pass_hit    = 32'(stab_cnt) >= STABLE_CYC;
    assign timeout_hit = 32'(run_cnt) >= TIMEOUT_CYC;

    // Next state and registered-output next values.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        iv_load  = 1'b0;
        iv_val   = '0;
        run_step = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start_rise) begin
                    state_d = ST_PRE;
                    accept  = 1'b1;
                    iv_load = 1'b1;
                    iv_val  = RUN_CNT_W'(PRE_CYC - 1);
                end
            end
            ST_PRE: begin
                if (iv_cnt == '0) begin
                    state_d = ST_RST;
                    iv_load = 1'b1;
                    iv_val  = RUN_CNT_W'(RST_CYC - 1);
                end
            end
            ST_RST: begin
                if (iv_cnt == '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                // The timeout edge itself is not a run cycle, so counts freeze there.
                run_step = ~timeout_hit;
                if (pass_hit)         state_d = ST_PASS;
                else if (timeout_hit) state_d = ST_FAIL;
            end
            default: state_d = ST_IDLE;
        endcase

        core_reset_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        pass_d       = 1'b0;
        fail_d       = 1'b0;
        unique case (state_d)
            ST_PRE, ST_RUN: busy_d = 1'b1;
            ST_RST:  begin busy_d = 1'b1; core_reset_d = 1'b1; end
            ST_PASS: begin done_d = 1'b1; pass_d = 1'b1; core_reset_d = 1'b1; end
            ST_FAIL: begin done_d = 1'b1; fail_d = 1'b1; core_reset_d = 1'b1; end
            default: core_reset_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            exp_in_q     <= '0;
            exp_q        <= '0;
            last_q       <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            start_prev_q <= start_q;
            exp_in_q     <= exp_val;
            if (accept) exp_q <= exp_in_q;
            if (accept)        last_q <= '0;
            else if (run_step) last_q <= core_out;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
        end
    end

    // PRE/RST interval, counted down from the loaded length.
    myth_mon_cnt #(.W(RUN_CNT_W)) u_iv_cnt (
        .clk        (clk),
        .rst_ni     (reset),
        .clr_i      (1'b0),
        .load_i     (iv_load),
        .load_val_i (iv_val),
        .en_i       ((state_q == ST_PRE) || (state_q == ST_RST)),
        .up_i       (1'b0),
        .cnt_o      (iv_cnt)
    );

    myth_mon_cnt #(.W(RUN_CNT_W)) u_run_cnt (
        .clk        (clk),
        .rst_ni     (reset),
        .clr_i      (accept),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (run_step),
        .up_i       (1'b1),
        .cnt_o      (run_cnt)
    );

    myth_mon_cnt #(.W(STAB_CNT_W)) u_stab_cnt (
        .clk        (clk),
        .rst_ni     (reset),
        .clr_i      (accept | (run_step & mismatch)),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (run_step & ~mismatch),
        .up_i       (1'b1),
        .cnt_o      (stab_cnt)
    );

    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign run_cycles = run_cnt;
    assign last_out   = last_q;

endmodule
